epu_layer_sched: RTL and testbench
==================================

// Module: epu_layer_sched
// PURPOSE
//  Layer sequencer in front of the ConvAcc datapath. The CPU queues per-layer commands
//  (weight word, mode, last flag) into an internal FIFO, then starts execution with go_i.
//  The block issues start/mode/w8 to ConvAcc for each queued layer and waits for finish.
//  It ping-pongs the In/Out buffer transpose bits between layers and raises a
//  network-done interrupt after the last layer.
// PARAMETERS
//  DEPTH        8   command FIFO entries (power of 2, >=2)
//  DATA_BITS    32  width of the weight (w8) word
//  MODE_BITS    4   width of the ConvAcc mode field
//  CNT_BITS     8   width of the layer counter
//  TIMEOUT_BITS 20  watchdog width (used only with EPU_SCHED_TIMEOUT_EN)
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous reset, active-high
//  cmd_valid_i  in   1          command push request
//  cmd_ready_o  out  1          FIFO not full (= ~full)
//  cmd_w8_i     in   DATA_BITS  layer weight word
//  cmd_mode_i   in   MODE_BITS  layer ConvAcc mode
//  cmd_last_i   in   1          last layer of the network
//  go_i         in   1          start executing queued commands (pulse)
//  abort_i      in   1          stop, flush FIFO, return to IDLE
//  irq_clr_i    in   1          acknowledge done_irq_o / err_o
//  conv_start_o out  1          level start to ConvAcc, held until finish
//  conv_mode_o  out  MODE_BITS  mode of the current layer
//  conv_w8_o    out  DATA_BITS  weight word of the current layer
//  in_trans_o   out  1          Input buffer transpose (layer parity)
//  out_trans_o  out  1          Output buffer transpose (layer parity)
//  conv_fin_i   in   1          ConvAcc finish pulse
//  busy_o       out  1          state != IDLE
//  done_irq_o   out  1          network done, level until irq_clr_i
//  err_o        out  1          watchdog expired, level until cleared
//  layer_cnt_o  out  CNT_BITS   completed layers since go_i
// BEHAVIOUR
//  - Reset values: all outputs 0, except cmd_ready_o = 1. FIFO empty, state IDLE, parity 0.
//  - Push: accepted when cmd_valid_i & cmd_ready_o. Push while full is dropped.
//    Push and pop in the same cycle is allowed when the FIFO is not full.
//  - FSM transitions:
//    - IDLE:  go_i & ~empty -> LOAD. go_i with an empty FIFO is ignored.
//    - LOAD:  pop the head; register w8, mode and last; set conv_start_o = 1 -> RUN.
//      Start therefore rises 2 cycles after go_i is sampled.
//    - RUN:   conv_start_o, conv_mode_o and conv_w8_o are held stable.
//      On conv_fin_i: conv_start_o = 0, layer_cnt_o += 1 (wraps), parity toggles.
//      Then go to DONE if last is set, otherwise GAP.
//    - GAP:   conv_start_o stays low for at least 1 cycle (ConvAcc re-arm).
//      ~empty -> LOAD; empty -> remain in GAP (stall, busy_o = 1).
//    - DONE:  done_irq_o = 1. irq_clr_i -> IDLE; layer_cnt_o and parity cleared.
//  - Layer timing: finish at cycle t gives start low at t+1 and start high at t+3
//    when a command is queued.
//  - in_trans_o = out_trans_o = parity; both update only on a conv_fin_i accepted in RUN.
//  - conv_fin_i outside RUN is ignored. go_i outside IDLE is ignored.
//  - abort_i (any state) has priority over all other inputs. Next cycle:
//    - state IDLE, FIFO flushed, conv_start_o = 0;
//    - done_irq_o, err_o, parity and layer_cnt_o cleared.
//    - A same-cycle push is dropped.
//  - irq_clr_i together with go_i in DONE: clear only; go_i is ignored.
//  - rst mid-layer: all state returns to reset values; ConvAcc sees start fall.
// CONFIGURATION
//  EPU_SCHED_TIMEOUT_EN defined:
//   - A TIMEOUT_BITS counter clears on entry to RUN and increments each RUN cycle.
//   - At all-ones without conv_fin_i: state ERR, conv_start_o = 0, err_o = 1.
//   - ERR exits to IDLE with a FIFO flush on irq_clr_i or abort_i.
//   - conv_fin_i in the same cycle as expiry wins (normal completion).
//  EPU_SCHED_TIMEOUT_EN undefined: no counter, no ERR state, err_o tied to 0.
// TESTING
//  1. Single layer:
//     - Push {w8=0xA5A5_0001, mode=3, last=1}, then go_i.
//     - Expect start=1 at go+2 with mode=3 and w8=0xA5A5_0001.
//     - fin -> start=0, done_irq_o=1, layer_cnt_o=1, in_trans/out_trans=1.
//     - irq_clr_i -> IDLE, layer_cnt_o=0.
//  2. Three layers (last on the 3rd):
//     - Parity goes 0->1->0->1.
//     - Start is low for exactly 2 cycles between layers.
//     - done_irq_o only after the 3rd fin; layer_cnt_o=3.
//  3. FIFO full:
//     - Push DEPTH+2 commands with go low: cmd_ready_o=0 after the 8th; extras dropped.
//     - Run all 8 (last on the 8th): layer_cnt_o=8.
//  4. Starvation:
//     - Queue 1 non-last command, go, fin: GAP stall with busy_o=1 and start=0.
//     - Push a last command 10 cycles later: start rises 2 cycles after the push.
//  5. Abort mid-RUN with 3 commands queued:
//     - Next cycle: start=0, IDLE, cmd_ready_o=1.
//     - A later go_i is ignored (FIFO empty).
//  6. With EPU_SCHED_TIMEOUT_EN and TIMEOUT_BITS=4:
//     - No fin: err_o=1 after 15 RUN cycles and start=0.
//     - irq_clr_i -> IDLE.
//     - fin exactly on cycle 15: no error.

Source files
------------

// File: rtl/epu_layer_sched.sv
// Layer sequencer for ConvAcc: queues per-layer commands, issues start/mode/w8 per layer,
// ping-pongs buffer transpose parity and flags network completion. Option: EPU_SCHED_TIMEOUT_EN.
module epu_layer_sched #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned MODE_BITS    = 4,
    parameter int unsigned CNT_BITS     = 8,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [DATA_BITS-1:0] cmd_w8_i,
    input  logic [MODE_BITS-1:0] cmd_mode_i,
    input  logic                 cmd_last_i,
    input  logic                 go_i,
    input  logic                 abort_i,
    input  logic                 irq_clr_i,
    output logic                 conv_start_o,
    output logic [MODE_BITS-1:0] conv_mode_o,
    output logic [DATA_BITS-1:0] conv_w8_o,
    output logic                 in_trans_o,
    output logic                 out_trans_o,
    input  logic                 conv_fin_i,
    output logic                 busy_o,
    output logic                 done_irq_o,
    output logic                 err_o,
    output logic [CNT_BITS-1:0]  layer_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DATA_BITS + MODE_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [EW-1:0]          mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic                   start_q, start_d;
    logic [MODE_BITS-1:0]   mode_q, mode_d;
    logic [DATA_BITS-1:0]   w8_q, w8_d;
    logic                   last_q, last_d;
    logic                   par_q, par_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   full_s, empty_s, push_s, pop_s, flush_s;
    logic [EW-1:0]          head_s;

    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    // An abort drops any push offered in the same cycle.
    assign push_s  = cmd_valid_i & ~full_s & ~abort_i;
    assign head_s  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef EPU_SCHED_TIMEOUT_EN
    localparam logic [TIMEOUT_BITS-1:0] TMR_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};
    logic [TIMEOUT_BITS-1:0] tmr_q;

    // Watchdog: zeroed while loading a layer, counts every RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else if (state_q == S_LOAD) begin
            tmr_q <= '0;
        end else if (state_q == S_RUN) begin
            tmr_q <= tmr_q + TIMEOUT_BITS'(1);
        end else begin
            tmr_q <= tmr_q;
        end
    end
`endif

    // Next-state, layer registers and FIFO pointer control.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        mode_d  = mode_q;
        w8_d    = w8_q;
        last_d  = last_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        pop_s   = 1'b0;
        flush_s = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            start_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            par_d   = 1'b0;
            cnt_d   = '0;
            flush_s = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go_i && !empty_s) state_d = S_LOAD;
                    else                  state_d = S_IDLE;
                end
                S_LOAD: begin
                    pop_s   = 1'b1;
                    {last_d, mode_d, w8_d} = head_s;
                    start_d = 1'b1;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (conv_fin_i) begin
                        start_d = 1'b0;
                        cnt_d   = cnt_q + CNT_BITS'(1);
                        par_d   = ~par_q;
                        if (last_q) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_GAP;
                        end
`ifdef EPU_SCHED_TIMEOUT_EN
                    end else if (tmr_q == TMR_LAST) begin
                        start_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_ERR;
`endif
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_GAP: begin
                    // A push arriving now is readable by LOAD next cycle.
                    if (!empty_s || push_s) state_d = S_LOAD;
                    else                    state_d = S_GAP;
                end
                S_DONE: begin
                    if (irq_clr_i) begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_ERR: begin
                    if (irq_clr_i) begin
                        state_d = S_IDLE;
                        err_d   = 1'b0;
                        flush_s = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    start_d = 1'b0;
                end
            endcase
        end
        if (flush_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + (push_s ? (AW+1)'(1) : (AW+1)'(0));
            rd_ptr_d = rd_ptr_q + (pop_s  ? (AW+1)'(1) : (AW+1)'(0));
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            start_q  <= 1'b0;
            mode_q   <= '0;
            w8_q     <= '0;
            last_q   <= 1'b0;
            par_q    <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            start_q  <= start_d;
            mode_q   <= mode_d;
            w8_q     <= w8_d;
            last_q   <= last_d;
            par_q    <= par_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Command storage; contents are qualified by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_last_i, cmd_mode_i, cmd_w8_i};
        end else begin
            mem_q[wr_ptr_q[AW-1:0]] <= mem_q[wr_ptr_q[AW-1:0]];
        end
    end

    assign cmd_ready_o  = ~full_s;
    assign conv_start_o = start_q;
    assign conv_mode_o  = mode_q;
    assign conv_w8_o    = w8_q;
    assign in_trans_o   = par_q;
    assign out_trans_o  = par_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_irq_o   = done_q;
    assign err_o        = err_q;
    assign layer_cnt_o  = cnt_q;

endmodule

// File: tb/tb_epu_layer_sched.sv
// Self-checking bench for epu_layer_sched: directed steps plus random networks checked
// against a queue-based model of the layer timing rules.
module tb_epu_layer_sched;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_last = 1'b0, go = 1'b0, abort = 1'b0;
    logic        irq_clr = 1'b0, fin = 1'b0;
    logic [31:0] cmd_w8 = 32'd0;
    logic [3:0]  cmd_mode = 4'd0;
    logic        cmd_ready, start, in_trans, out_trans, busy, done_irq, err;
    logic [3:0]  mode_o;
    logic [31:0] w8_o;
    logic [7:0]  layer_cnt;

    epu_layer_sched #(.DEPTH(8), .DATA_BITS(32), .MODE_BITS(4), .CNT_BITS(8), .TIMEOUT_BITS(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_w8_i(cmd_w8), .cmd_mode_i(cmd_mode), .cmd_last_i(cmd_last), .go_i(go),
        .abort_i(abort), .irq_clr_i(irq_clr), .conv_start_o(start), .conv_mode_o(mode_o),
        .conv_w8_o(w8_o), .in_trans_o(in_trans), .out_trans_o(out_trans), .conv_fin_i(fin),
        .busy_o(busy), .done_irq_o(done_irq), .err_o(err), .layer_cnt_o(layer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w8;
        logic [3:0]  mode;
        logic        last;
    } cmd_t;

    cmd_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic [3:0] m, input logic l);
        cmd_t c;
        chk("ready_before_push", 64'(cmd_ready), 64'(q.size() < DEPTH));
        c.w8 = w; c.mode = m; c.last = l;
        cmd_w8 = w; cmd_mode = m; cmd_last = l; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        if (q.size() < DEPTH) q.push_back(c);
    endtask

    // Runs the queued network: start at go+2, fin->start low 2 cycles, parity = layers mod 2.
    task automatic run_net(input bit keep_done);
        cmd_t c;
        int   k = 0;
        go = 1'b1; tick(); go = 1'b0;
        chk("start_go_plus1", 64'(start), 64'd0);
        chk("busy_after_go", 64'(busy), 64'd1);
        tick();
        while (q.size() > 0) begin
            c = q.pop_front();
            chk("start_high", 64'(start), 64'd1);
            chk("mode", 64'(mode_o), 64'(c.mode));
            chk("w8", 64'(w8_o), 64'(c.w8));
            repeat ($urandom_range(0, 4)) begin
                tick();
                chk("start_held", 64'(start), 64'd1);
                chk("w8_held", 64'(w8_o), 64'(c.w8));
            end
            fin = 1'b1; tick(); fin = 1'b0;
            k++;
            chk("start_low_fin1", 64'(start), 64'd0);
            chk("layer_cnt", 64'(layer_cnt), 64'(k));
            chk("in_trans", 64'(in_trans), 64'(k % 2));
            chk("out_trans", 64'(out_trans), 64'(k % 2));
            chk("done_irq", 64'(done_irq), 64'(c.last));
            if (c.last) break;
            tick();
            chk("start_low_fin2", 64'(start), 64'd0);
            tick();
        end
        if (!keep_done) begin
            irq_clr = 1'b1; tick(); irq_clr = 1'b0;
            chk("clr_done", 64'(done_irq), 64'd0);
            chk("clr_busy", 64'(busy), 64'd0);
            chk("clr_cnt", 64'(layer_cnt), 64'd0);
            chk("clr_trans", 64'(in_trans), 64'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done_irq), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cnt", 64'(layer_cnt), 64'd0);
        chk("rst_trans", 64'({in_trans, out_trans}), 64'd0);

        // Finish and go with nothing queued are ignored.
        fin = 1'b1; go = 1'b1; tick(); fin = 1'b0; go = 1'b0; tick();
        chk("idle_fin_cnt", 64'(layer_cnt), 64'd0);
        chk("idle_go_busy", 64'(busy), 64'd0);

        push(32'hA5A5_0001, 4'd3, 1'b1);
        run_net(1'b0);

        push(32'h1000_0001, 4'd1, 1'b0);
        push(32'h1000_0002, 4'd2, 1'b0);
        push(32'h1000_0003, 4'd5, 1'b1);
        run_net(1'b0);

        // FIFO full: the two extras are dropped.
        for (int i = 0; i < DEPTH + 2; i++)
            push(32'hF000_0000 + 32'(i), 4'(i), (i == DEPTH - 1));
        chk("full_ready", 64'(cmd_ready), 64'd0);
        chk("full_model_depth", 64'(q.size()), 64'(DEPTH));
        run_net(1'b0);

        // Starvation in GAP.
        push(32'h5555_0001, 4'd2, 1'b0);
        go = 1'b1; tick(); go = 1'b0; tick();
        chk("starve_start", 64'(start), 64'd1);
        void'(q.pop_front());
        fin = 1'b1; tick(); fin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("gap_start", 64'(start), 64'd0);
            chk("gap_busy", 64'(busy), 64'd1);
            chk("gap_cnt", 64'(layer_cnt), 64'd1);
            fin = (i == 4);
            tick();
            fin = 1'b0;
        end
        push(32'h5555_0002, 4'd7, 1'b1);
        chk("starve_push1", 64'(start), 64'd0);
        tick();
        chk("starve_push2", 64'(start), 64'd1);
        chk("starve_w8", 64'(w8_o), 64'h5555_0002);
        chk("starve_mode", 64'(mode_o), 64'd7);
        void'(q.pop_front());
        fin = 1'b1; tick(); fin = 1'b0;
        chk("starve_done", 64'(done_irq), 64'd1);
        chk("starve_cnt", 64'(layer_cnt), 64'd2);
        chk("starve_par", 64'(in_trans), 64'd0);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;

        // Abort mid-RUN with a same-cycle push.
        push(32'hAB00_0001, 4'd1, 1'b0);
        push(32'hAB00_0002, 4'd1, 1'b0);
        push(32'hAB00_0003, 4'd1, 1'b0);
        push(32'hAB00_0004, 4'd1, 1'b1);
        go = 1'b1; tick(); go = 1'b0; tick();
        chk("abort_pre_start", 64'(start), 64'd1);
        abort = 1'b1; cmd_valid = 1'b1; tick(); abort = 1'b0; cmd_valid = 1'b0;
        q.delete();
        chk("abort_start", 64'(start), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        go = 1'b1; tick(); go = 1'b0; tick();
        chk("abort_go_ignored", 64'(busy), 64'd0);
        chk("abort_go_start", 64'(start), 64'd0);

        // irq_clr with go in DONE: clear only.
        push(32'hCC00_0001, 4'd4, 1'b1);
        run_net(1'b1);
        push(32'hCC00_0002, 4'd6, 1'b1);
        irq_clr = 1'b1; go = 1'b1; tick(); irq_clr = 1'b0; go = 1'b0;
        chk("clrgo_done", 64'(done_irq), 64'd0);
        tick();
        chk("clrgo_busy", 64'(busy), 64'd0);
        run_net(1'b0);

        // Reset in the middle of a layer.
        push(32'hDD00_0001, 4'd2, 1'b1);
        go = 1'b1; tick(); go = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        q.delete();
        chk("midrst_start", 64'(start), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);

        // Random networks.
        for (int net = 0; net < 6; net++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++)
                push($urandom, 4'($urandom_range(0, 15)), (i == n - 1));
            run_net(1'b0);
        end

`ifdef EPU_SCHED_TIMEOUT_EN
        push(32'hEE00_0001, 4'd1, 1'b1);
        go = 1'b1; tick(); go = 1'b0; tick();
        void'(q.pop_front());
        chk("wd_start0", 64'(start), 64'd1);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("wd_start_run", 64'(start), 64'd1);
        end
        tick();
        chk("wd_err", 64'(err), 64'd1);
        chk("wd_start_low", 64'(start), 64'd0);
        chk("wd_busy", 64'(busy), 64'd1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk("wd_clr_err", 64'(err), 64'd0);
        chk("wd_clr_busy", 64'(busy), 64'd0);
        push(32'hEE00_0002, 4'd2, 1'b1);
        go = 1'b1; tick(); go = 1'b0; tick();
        void'(q.pop_front());
        repeat (14) tick();
        fin = 1'b1; tick(); fin = 1'b0;
        chk("wd_fin_no_err", 64'(err), 64'd0);
        chk("wd_fin_done", 64'(done_irq), 64'd1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
`else
        chk("err_tied_low", 64'(err), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
